alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command, result and host preload bundle for alu_seq.
// The slave modport is the block's view; master is the driver's view.
interface alu_seq_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_ra;
   logic [ADDR_W-1:0] cmd_rb;
   logic [ADDR_W-1:0] cmd_rd;
   logic              cmd_wb;
   logic              res_valid;
   logic              res_ready;
   logic [WIDTH-1:0]  res_data;
   logic [4:0]        res_flags;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
      input  res_ready, wr_en, wr_addr, wr_data,
      output cmd_ready, res_valid, res_data, res_flags, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
      output res_ready, wr_en, wr_addr, wr_data,
      input  cmd_ready, res_valid, res_data, res_flags, busy
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU over a small register file: fetch A, fetch B, execute,
// optional writeback, then hold the result until the consumer takes it.
module alu_seq #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 3
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int MSB   = WIDTH-1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH_A = 3'd1;
   localparam logic [2:0] S_FETCH_B = 3'd2;
   localparam logic [2:0] S_EXEC    = 3'd3;
   localparam logic [2:0] S_WB      = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADC  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_PASS = 4'd8;

   logic [2:0]        r_state;
   logic [3:0]        r_op;
   logic [ADDR_W-1:0] r_ra, r_rb, r_rd;
   logic              r_wb;
   logic [WIDTH-1:0]  r_t1, r_t2;
   logic [WIDTH-1:0]  r_res;
   logic [4:0]        r_flags;
   logic              r_c;
   logic [WIDTH-1:0]  r_rf [DEPTH];

   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_res;
   logic              w_c, w_v, w_err;
   logic [4:0]        w_flags;
   logic [WIDTH-1:0]  w_rd_a, w_rd_b;

   // Entry 0 is never written, but the guard keeps the zero-register explicit.
   assign w_rd_a = (r_ra == '0) ? '0 : r_rf[r_ra];
   assign w_rd_b = (r_rb == '0) ? '0 : r_rf[r_rb];

   always_comb begin
      w_sum = '0;
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_err = 1'b0;
      case (r_op)
         OP_ADD, OP_ADC: begin
            w_sum = {1'b0, r_t1} + {1'b0, r_t2}
                  + {{WIDTH{1'b0}}, (r_op == OP_ADC) & r_c};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_t1[MSB] == r_t2[MSB]) && (w_res[MSB] != r_t1[MSB]);
         end
         OP_SUB: begin
            // Top bit of the widened difference is the unsigned borrow.
            w_sum = {1'b0, r_t1} - {1'b0, r_t2};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_t1[MSB] != r_t2[MSB]) && (w_res[MSB] != r_t1[MSB]);
         end
         OP_AND:  w_res = r_t1 & r_t2;
         OP_OR:   w_res = r_t1 | r_t2;
         OP_XOR:  w_res = r_t1 ^ r_t2;
         OP_SHL: begin
            w_res = {r_t1[MSB-1:0], 1'b0};
            w_c   = r_t1[MSB];
         end
         OP_SHR: begin
            w_res = {1'b0, r_t1[MSB:1]};
            w_c   = r_t1[0];
         end
         OP_PASS: w_res = r_t1;
         default: w_err = 1'b1;
      endcase
      w_flags = w_err ? 5'b10000 : {1'b0, w_v, w_res[MSB], (w_res == '0), w_c};
      if (w_err) w_res = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rd    <= '0;
         r_wb    <= 1'b0;
         r_t1    <= '0;
         r_t2    <= '0;
         r_res   <= '0;
         r_flags <= '0;
         r_c     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.wr_en && bus.wr_addr != '0) r_rf[bus.wr_addr] <= bus.wr_data;
               if (bus.cmd_valid) begin
                  r_op    <= bus.cmd_op;
                  r_ra    <= bus.cmd_ra;
                  r_rb    <= bus.cmd_rb;
                  r_rd    <= bus.cmd_rd;
                  r_wb    <= bus.cmd_wb;
                  r_state <= S_FETCH_A;
               end
            end
            S_FETCH_A: begin
               r_t1    <= w_rd_a;
               r_state <= S_FETCH_B;
            end
            S_FETCH_B: begin
               r_t2    <= w_rd_b;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_res   <= w_res;
               r_flags <= w_flags;
               r_c     <= w_flags[0];
               r_state <= S_WB;
            end
            S_WB: begin
               if (r_wb && !r_flags[4] && r_rd != '0) r_rf[r_rd] <= r_res;
               r_state <= S_RESP;
            end
            S_RESP: if (bus.res_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.res_valid = (r_state == S_RESP);
   assign bus.res_data  = r_res;
   assign bus.res_flags = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a reference model predicts each result when
// the command is driven; the queued prediction is compared when res_valid rises.
module tb_alu_seq;
   localparam int W  = 32;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
   alu_seq #(.WIDTH(W), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int            n_run  = 0;
   int            n_fail = 0;
   logic [W-1:0]  m_rf [8];
   logic          m_c;
   logic [36:0]   sb_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ERR,V,N,Z,C,data}; overflow judged by true signed range.
   function automatic logic [36:0] mdl(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic cin);
      logic [63:0] s;
      logic [31:0] r;
      logic        c, v, e;
      longint      sa, sb, sr;
      s = '0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0; sr = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0: begin s = {32'd0, a} + {32'd0, b}; r = s[31:0]; c = s[32]; sr = sa + sb; end
         4'd1: begin
            s = {32'd0, a} + {32'd0, b} + {63'd0, cin};
            r = s[31:0]; c = s[32]; sr = sa + sb + (cin ? 64'sd1 : 64'sd0);
         end
         4'd2: begin r = a - b; c = (a < b); sr = sa - sb; end
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         4'd6: begin r = a << 1; c = a[31]; end
         4'd7: begin r = a >> 1; c = a[0]; end
         4'd8: r = a;
         default: e = 1'b1;
      endcase
      if (op <= 4'd2) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return e ? {5'b10000, 32'd0} : {1'b0, v, r[31], (r == 32'd0), c, r};
   endfunction

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ra = '0; bus.cmd_rb = '0;
      bus.cmd_rd = '0; bus.cmd_wb = 1'b0; bus.res_ready = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
   endtask

   task automatic preload(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (a != 3'd0) m_rf[a] = d;
   endtask

   task automatic run_cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd, input logic wb, input int hold,
                          input logic wen, input logic [2:0] wa, input logic [31:0] wd);
      logic [36:0] exp, got, first;
      int n;
      @(negedge clk);
      if (wen) begin
         bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
         if (wa != 3'd0) m_rf[wa] = wd;
      end
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb;
      bus.cmd_rd = rd; bus.cmd_wb = wb;
      chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      exp = mdl(op, m_rf[ra], m_rf[rb], m_c);
      sb_q.push_back(exp);
      m_c = exp[32];
      if (wb && !exp[36] && rd != 3'd0) m_rf[rd] = exp[31:0];
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.wr_en = 1'b0;
      n = 1;
      while (!bus.res_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("latency", 64'(n), 64'd5);
      got = {bus.res_flags, bus.res_data};
      exp = sb_q.pop_front();
      chk("res_data", 64'(got[31:0]), 64'(exp[31:0]));
      chk("res_flags", 64'(got[36:32]), 64'(exp[36:32]));
      first = got;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         chk("hold_valid", 64'(bus.res_valid), 64'd1);
         chk("hold_ready", 64'(bus.cmd_ready), 64'd0);
         chk("hold_stable", 64'({bus.res_flags, bus.res_data}), 64'(first));
      end
      bus.wr_en = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk("idle_after", 64'(bus.busy), 64'd0);
   endtask

   task automatic cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] rd, input logic wb);
      run_cmd(op, ra, rb, rd, wb, 0, 1'b0, 3'd0, 32'd0);
   endtask

   initial begin
      logic [3:0] rop;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_c = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_data", 64'(bus.res_data), 64'd0);
      chk("rst_flags", 64'(bus.res_flags), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

      // Basic add with writeback, then read back through PASS
      preload(3'd1, 32'd5);
      preload(3'd2, 32'd3);
      cmd(4'd0, 3'd1, 3'd2, 3'd3, 1'b1);
      cmd(4'd8, 3'd3, 3'd0, 3'd0, 1'b0);
      chk("r3_model", 64'(m_rf[3]), 64'd8);

      // Borrow, then ADC consuming the stored carry
      cmd(4'd2, 3'd2, 3'd1, 3'd0, 1'b0);
      cmd(4'd1, 3'd0, 3'd0, 3'd0, 1'b0);

      // Signed overflow and carry-out wrap to zero
      preload(3'd1, 32'h7FFF_FFFF);
      preload(3'd2, 32'd1);
      cmd(4'd0, 3'd1, 3'd2, 3'd0, 1'b0);
      preload(3'd1, 32'hFFFF_FFFF);
      cmd(4'd0, 3'd1, 3'd2, 3'd0, 1'b0);
      cmd(4'd1, 3'd2, 3'd0, 3'd0, 1'b0);

      // Logic ops and shifts
      preload(3'd3, 32'hA5A5_0F0F);
      preload(3'd4, 32'h0FF0_8001);
      for (int o = 3; o <= 7; o++) cmd(4'(o), 3'd3, 3'd4, 3'd0, 1'b0);
      cmd(4'd6, 3'd1, 3'd0, 3'd0, 1'b0);
      cmd(4'd7, 3'd4, 3'd0, 3'd0, 1'b0);

      // Illegal opcode never writes back; r0 ignores writeback
      preload(3'd4, 32'h0000_1234);
      cmd(4'd9, 3'd3, 3'd4, 3'd4, 1'b1);
      cmd(4'd8, 3'd4, 3'd0, 3'd0, 1'b0);
      cmd(4'd0, 3'd3, 3'd4, 3'd0, 1'b1);
      cmd(4'd8, 3'd0, 3'd0, 3'd0, 1'b0);
      cmd(4'd15, 3'd1, 3'd2, 3'd0, 1'b0);

      // Back-pressure in RESP with host writes that must be ignored
      preload(3'd5, 32'h0000_0055);
      run_cmd(4'd0, 3'd5, 3'd5, 3'd6, 1'b1, 10, 1'b0, 3'd0, 32'd0);
      cmd(4'd8, 3'd5, 3'd0, 3'd0, 1'b0);

      // Host write landing on the same edge as acceptance is seen by the fetch
      run_cmd(4'd8, 3'd7, 3'd0, 3'd0, 1'b0, 0, 1'b1, 3'd7, 32'h1357_9BDF);

      // Randomised mix including illegal opcodes and ADC chains
      for (int k = 0; k < 20; k++) begin
         if ($urandom_range(0, 2) == 0)
            preload(3'($urandom_range(1, 7)), $urandom);
         rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         cmd(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      // Reset during EXEC of a writeback command aborts it
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.cmd_ra = 3'd1; bus.cmd_rb = 3'd2;
      bus.cmd_rd = 3'd6; bus.cmd_wb = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_valid", 64'(bus.res_valid), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_c = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("abort_no_res", 64'(bus.res_valid), 64'd0);
      cmd(4'd8, 3'd6, 3'd0, 3'd0, 1'b0);
      cmd(4'd8, 3'd1, 3'd0, 3'd0, 1'b0);
      cmd(4'd1, 3'd0, 3'd0, 3'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
